// File: rtl/approx_add_pipe_if.sv
// Streaming operand/result bundle for the approximate adder pipeline.
// The DUT is the slave; the producer/consumer side is the master.
interface approx_add_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic [1:0]       out_mode;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_sum, out_mode
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_mode
    );
endinterface

// File: rtl/approx_add_pipe.sv
// Two-stage signed adder: stage 1 forms the (optionally approximate) low
// K bits and carry, stage 2 adds the sign-extended upper parts.
module approx_add_pipe #(
    parameter int WIDTH      = 16,
    parameter int APPROX_LSB = 5
) (
    input logic               clk,
    input logic               rst,
    approx_add_pipe_if.slave  bus
);
    localparam int K  = APPROX_LSB;
    localparam int UW = WIDTH - K;

    logic          v1_q, v2_q;
    logic          adv1, adv2;
    logic [K-1:0]  l1_q, l_d;
    logic          c1_q, c_d;
    logic [UW-1:0] ah1_q, bh1_q;
    logic [1:0]    mode1_q, mode_d;
    logic [UW:0]   u_d;
    logic [WIDTH:0] sum2_q, sum_d;
    logic [1:0]    mode2_q;
    logic [K-1:0]  a_lo, b_lo;

    assign adv2 = !v2_q | bus.out_ready;
    assign adv1 = !v1_q | adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2_q;
    assign bus.out_sum   = sum2_q;
    assign bus.out_mode  = mode2_q;

    assign a_lo = bus.in_a[K-1:0];
    assign b_lo = bus.in_b[K-1:0];

    // Reserved mode 11 behaves and reports as EXACT.
    assign mode_d = (bus.in_mode == 2'b11) ? 2'b00 : bus.in_mode;

    always_comb begin
        l_d = '0;
        c_d = 1'b0;
        unique case (mode_d)
            2'b01: begin
                l_d = a_lo | b_lo;
                c_d = a_lo[K-1] & b_lo[K-1];
            end
            2'b10: begin
                l_d = a_lo;
                c_d = 1'b0;
            end
            default: {c_d, l_d} = {1'b0, a_lo} + {1'b0, b_lo};
        endcase
    end

    assign u_d = {ah1_q[UW-1], ah1_q}
               + {bh1_q[UW-1], bh1_q}
               + {{UW{1'b0}}, c1_q};

    assign sum_d = {u_d, l1_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            l1_q    <= '0;
            c1_q    <= 1'b0;
            ah1_q   <= '0;
            bh1_q   <= '0;
            mode1_q <= 2'b00;
            sum2_q  <= '0;
            mode2_q <= 2'b00;
        end else begin
            if (adv1) begin
                v1_q <= bus.in_valid;
                if (bus.in_valid) begin
                    l1_q    <= l_d;
                    c1_q    <= c_d;
                    ah1_q   <= bus.in_a[WIDTH-1:K];
                    bh1_q   <= bus.in_b[WIDTH-1:K];
                    mode1_q <= mode_d;
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    sum2_q  <= sum_d;
                    mode2_q <= mode1_q;
                end
            end
        end
    end
endmodule
